alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer for a single-bus datapath: walks fetch (T0-T2) and execute
// (T3-T6) microsteps and decodes Moore strobes from the current step and IR.
module alu_op_sequencer #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                start,
  input  logic                mem_rdy,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [3:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_ILL, C_3R, C_MD, C_UN} cls_t;

  state_t state_q, state_d;
  cls_t   cls;
  logic [3:0]           op_sel;
  logic [4:0]           opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic                 unused_ir;

  assign opcode    = IR[DATA_W-1 -: 5];
  assign ra        = IR[DATA_W-6 -: REG_SEL_W];
  assign rb        = IR[DATA_W-6-REG_SEL_W -: REG_SEL_W];
  assign rc        = IR[DATA_W-6-2*REG_SEL_W -: REG_SEL_W];
  assign unused_ir = ^IR[DATA_W-6-3*REG_SEL_W:0];

  function automatic logic reg_ok(input logic [REG_SEL_W-1:0] f);
    return int'(f) < NUM_REGS;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] f);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (reg_ok(f)) v[f] = 1'b1;
    return v;
  endfunction

  // Instruction class and ALU select; bad register fields demote to illegal.
  always_comb begin
    cls    = C_ILL;
    op_sel = 4'h0;
    case (opcode)
      5'd3:  begin cls = C_3R; op_sel = 4'h2; end
      5'd4:  begin cls = C_3R; op_sel = 4'h3; end
      5'd5:  begin cls = C_3R; op_sel = 4'h0; end
      5'd6:  begin cls = C_3R; op_sel = 4'h1; end
      5'd7:  begin cls = C_3R; op_sel = 4'hA; end
      5'd8:  begin cls = C_3R; op_sel = 4'hB; end
      5'd9:  begin cls = C_3R; op_sel = 4'h7; end
      5'd10: begin cls = C_3R; op_sel = 4'h8; end
      5'd11: begin cls = C_3R; op_sel = 4'h9; end
      5'd15: begin cls = C_MD; op_sel = 4'h4; end
      5'd16: begin cls = C_MD; op_sel = 4'h6; end
      5'd17: begin cls = C_UN; op_sel = 4'hC; end
      5'd18: begin cls = C_UN; op_sel = 4'hD; end
      default: ;
    endcase
    if (cls == C_3R && !(reg_ok(ra) && reg_ok(rb) && reg_ok(rc))) cls = C_ILL;
    if ((cls == C_MD || cls == C_UN) && !(reg_ok(ra) && reg_ok(rb))) cls = C_ILL;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    alu_op   = 4'h0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (cls)
          C_3R: begin Rout = onehot(rb); Yin = 1'b1; end
          C_MD: begin Rout = onehot(ra); Yin = 1'b1; end
          C_UN: begin Rout = onehot(rb); alu_op = op_sel; Zin = 1'b1; end
          default: illegal = 1'b1;
        endcase
        state_d = (cls == C_ILL) ? S_DONE : S_T4;
      end
      S_T4: begin
        case (cls)
          C_3R: begin Rout = onehot(rc); alu_op = op_sel; Zin = 1'b1; end
          C_MD: begin Rout = onehot(rb); alu_op = op_sel; Zin = 1'b1; end
          C_UN: begin Zlowout = 1'b1; Rin = onehot(ra); end
          default: ;
        endcase
        state_d = (cls == C_3R || cls == C_MD) ? S_T5 : S_DONE;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == C_MD) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Rin     = onehot(ra);
          state_d = S_DONE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: an expected-strobe trace is built per instruction
// and compared against the DUT on every falling edge.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        Resetn, start, mem_rdy;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, LOin, HIin;
  logic [15:0] Rout, Rin;
  logic [3:0]  alu_op;
  logic        busy, done, illegal;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(32), .NUM_REGS(16)) dut (
    .Clock(clk), .Resetn(Resetn), .start(start), .mem_rdy(mem_rdy), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .LOin(LOin), .HIin(HIin), .Rout(Rout), .Rin(Rin),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, LOin, HIin;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [3:0]  alu_op;
    logic busy, done, illegal;
  } obs_t;

  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 0;
  obs_t exp_q[$];
  obs_t seen[0:63];
  obs_t e_v, a_v;

  function automatic obs_t obs();
    obs_t v;
    v.PCout = PCout; v.Zlowout = Zlowout; v.Zhighout = Zhighout; v.MDRout = MDRout;
    v.MARin = MARin; v.Zin = Zin; v.PCin = PCin; v.MDRin = MDRin; v.IRin = IRin;
    v.Yin = Yin; v.IncPC = IncPC; v.Read = Read; v.LOin = LOin; v.HIin = HIin;
    v.Rout = Rout; v.Rin = Rin; v.alu_op = alu_op;
    v.busy = busy; v.done = done; v.illegal = illegal;
    return v;
  endfunction

  function automatic obs_t bz();
    obs_t v;
    v = '0;
    v.busy = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] f);
    return 16'd1 << f;
  endfunction

  function automatic logic [31:0] mk(input int opc, input int a, input int b, input int c);
    return {opc[4:0], a[3:0], b[3:0], c[3:0], 15'd0};
  endfunction

  // Expected per-cycle outputs, starting with the cycle in which start is raised.
  function automatic void build(input logic [31:0] ir, input int stalls);
    logic [4:0] opc;
    logic [3:0] ra, rb, rc, op;
    int   kind;
    obs_t v;
    opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    kind = 0; op = 4'h0;
    case (opc)
      5'd3:  begin kind = 1; op = 4'h2; end
      5'd4:  begin kind = 1; op = 4'h3; end
      5'd5:  begin kind = 1; op = 4'h0; end
      5'd6:  begin kind = 1; op = 4'h1; end
      5'd7:  begin kind = 1; op = 4'hA; end
      5'd8:  begin kind = 1; op = 4'hB; end
      5'd9:  begin kind = 1; op = 4'h7; end
      5'd10: begin kind = 1; op = 4'h8; end
      5'd11: begin kind = 1; op = 4'h9; end
      5'd15: begin kind = 2; op = 4'h4; end
      5'd16: begin kind = 2; op = 4'h6; end
      5'd17: begin kind = 3; op = 4'hC; end
      5'd18: begin kind = 3; op = 4'hD; end
      default: kind = 0;
    endcase
    exp_q.push_back('0);
    v = bz(); v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; exp_q.push_back(v);
    for (int i = 0; i <= stalls; i++) begin
      v = bz(); v.Zlowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1; exp_q.push_back(v);
    end
    v = bz(); v.MDRout = 1; v.IRin = 1; exp_q.push_back(v);
    case (kind)
      1: begin
        v = bz(); v.Rout = oh(rb); v.Yin = 1; exp_q.push_back(v);
        v = bz(); v.Rout = oh(rc); v.alu_op = op; v.Zin = 1; exp_q.push_back(v);
        v = bz(); v.Zlowout = 1; v.Rin = oh(ra); exp_q.push_back(v);
      end
      2: begin
        v = bz(); v.Rout = oh(ra); v.Yin = 1; exp_q.push_back(v);
        v = bz(); v.Rout = oh(rb); v.alu_op = op; v.Zin = 1; exp_q.push_back(v);
        v = bz(); v.Zlowout = 1; v.LOin = 1; exp_q.push_back(v);
        v = bz(); v.Zhighout = 1; v.HIin = 1; exp_q.push_back(v);
      end
      3: begin
        v = bz(); v.Rout = oh(rb); v.alu_op = op; v.Zin = 1; exp_q.push_back(v);
        v = bz(); v.Zlowout = 1; v.Rin = oh(ra); exp_q.push_back(v);
      end
      default: begin
        v = bz(); v.illegal = 1; exp_q.push_back(v);
      end
    endcase
    v = bz(); v.done = 1; exp_q.push_back(v);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      e_v = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'(0);
      a_v = obs();
      checks++;
      if (a_v !== e_v) begin
        failures++;
        $display("FAIL trace t=%0t actual=%h required=%h", $time, a_v, e_v);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the DUT idle.
  task automatic run_instr(input string nm, input logic [31:0] ir, input int stalls,
                           input int exp_lat, input bit start_in_done, input int pulse_at);
    int n;
    bit got;
    IR = ir;
    build(ir, stalls);
    mem_rdy = 1'b0;
    start   = 1'b1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
      if (n >= 2 + stalls) mem_rdy = 1'b1;
      seen[n] = obs();
      if (done) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done_by_%0d", nm, exp_lat);
      exp_q.delete();
    end else begin
      lit({nm, "_latency"}, n, exp_lat);
    end
    start = 1'b0;
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; mem_rdy = 1'b0; IR = '0;
    #1;
    lit("reset_state", 32'(obs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    Resetn = 1'b1;
    cmp_en = 1'b1;

    run_instr("and_r4_r5_r7", 32'h2A2B8000, 0, 7, 1'b1, 0);
    lit("and_t3_rout", seen[4].Rout, 32'h0020);
    lit("and_t3_yin", seen[4].Yin, 1);
    lit("and_t4_rout", seen[5].Rout, 32'h0080);
    lit("and_t4_zin", seen[5].Zin, 1);
    lit("and_t5_rin", seen[6].Rin, 32'h0010);

    run_instr("and_stall3", 32'h2A2B8000, 3, 10, 1'b0, 0);
    lit("stall_t1_first_read", seen[2].Read, 1);
    lit("stall_t1_last_mdrin", seen[5].MDRin, 1);
    lit("stall_t2_read", seen[6].Read, 0);

    run_instr("mul_r4_r3", 32'h7A180000, 0, 8, 1'b0, 3);
    lit("mul_t3_rout", seen[4].Rout, 32'h0010);
    lit("mul_t4_aluop", seen[5].alu_op, 32'h4);
    lit("mul_t5_loin", seen[6].LOin, 1);
    lit("mul_t6_hiin", seen[7].HIin, 1);

    run_instr("not_r1_r2", 32'h90900000, 0, 6, 1'b0, 0);
    lit("not_t3_aluop", seen[4].alu_op, 32'hD);
    lit("not_t4_rin", seen[5].Rin, 32'h0002);

    run_instr("illegal_zero", 32'h00000000, 0, 5, 1'b0, 0);
    lit("illegal_t3", seen[4].illegal, 1);
    lit("illegal_t2_clear", seen[3].illegal, 0);

    // Reset asserted while the AND instruction sits in T4.
    IR = 32'h2A2B8000;
    build(IR, 0);
    mem_rdy = 1'b0;
    start   = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n >= 2) mem_rdy = 1'b1;
    end
    lit("pre_reset_t4_zin", Zin, 1);
    Resetn = 1'b0;
    exp_q.delete();
    #1;
    lit("reset_mid_outputs", 32'(obs()), 32'd0);
    lit("reset_mid_busy", busy, 0);
    @(posedge clk); #1;
    Resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_instr("add_after_reset", mk(3, 1, 2, 3), 1, 8, 1'b0, 4);
    run_instr("div_r15_r0", mk(16, 15, 0, 0), 0, 8, 1'b0, 0);
    run_instr("neg_r0_r9", mk(17, 0, 9, 0), 2, 8, 1'b0, 0);
    run_instr("shl_r14_r13_r12", mk(11, 14, 13, 12), 0, 7, 1'b1, 0);
    run_instr("sub_r6_r8_r10", mk(4, 6, 8, 10), 0, 7, 1'b0, 2);
    run_instr("ror_r2_r3_r4", mk(7, 2, 3, 4), 0, 7, 1'b0, 0);
    run_instr("illegal_op31", mk(31, 1, 1, 1), 1, 6, 1'b0, 0);
    run_instr("illegal_op12", mk(12, 2, 3, 4), 0, 5, 1'b0, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
